// File: rtl/sample_window_capture.sv
// ============================================================================
// Module      : sample_window_capture
// Description : Packs SAMPLES beats of OSF oversampled bits into one window,
//               double-buffered (staging + output) behind valid/ready.
//               Optional macro SWC_FLUSH_EN adds flush / win_beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_window_capture #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OSF-1:0]           in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SAMPLES*OSF-1:0]   win_data,
    output logic                     win_valid,
    input  logic                     win_ready
`ifdef SWC_FLUSH_EN
    ,
    input  logic                     flush,
    output logic [$clog2(SAMPLES):0] win_beats
`endif
);

    localparam int              c_CW   = $clog2(SAMPLES);
    localparam int              c_WW   = SAMPLES * OSF;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SAMPLES - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [c_WW-1:0] r_stage;
    logic [c_WW-1:0] w_stage_next;
    logic [c_CW-1:0] r_beat_cnt;
    logic [c_WW-1:0] r_win_data;
    logic            r_win_valid;

    logic w_in_ready;
    logic w_accept;
    logic w_slot_free;
    logic w_last;
    logic w_close;
    logic w_load_out;

    assign w_in_ready  = (r_state == S_FILL) && !rst;
    assign w_accept    = in_valid && w_in_ready;
    assign w_slot_free = !r_win_valid || win_ready;
    assign w_last      = w_accept && (r_beat_cnt == c_LAST);

`ifdef SWC_FLUSH_EN
    logic [c_CW:0] r_stage_beats;
    logic [c_CW:0] r_win_beats;
    logic [c_CW:0] w_count;

    // Beats in the window being closed, including a beat accepted this cycle
    assign w_count = {1'b0, r_beat_cnt} + {{c_CW{1'b0}}, w_accept};
    assign w_close = w_last ||
                     (flush && (r_state == S_FILL) && !rst &&
                      ((r_beat_cnt != '0) || w_accept));
`else
    assign w_close = w_last;
`endif

    // Staging is all-zero at the start of every window, so a flushed
    // partial window is zero-padded without any masking.
    always_comb begin
        w_stage_next = r_stage;
        if (w_accept) begin
            w_stage_next[int'(r_beat_cnt)*OSF +: OSF] = in_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_out   = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_close) begin
                    if (w_slot_free) begin
                        w_load_out = 1'b1;
                    end else begin
                        w_state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (w_slot_free) begin
                    w_load_out   = 1'b1;
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage     <= '0;
            r_beat_cnt  <= '0;
            r_win_data  <= '0;
            r_win_valid <= 1'b0;
        end else if (w_load_out) begin
            // In FULL no beat is accepted, so w_stage_next equals r_stage
            r_win_data  <= w_stage_next;
            r_win_valid <= 1'b1;
            r_stage     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (r_win_valid && win_ready) begin
                r_win_valid <= 1'b0;
            end
            if (w_close) begin
                r_stage    <= w_stage_next;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_stage    <= w_stage_next;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

`ifdef SWC_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_beats <= '0;
            r_win_beats   <= '0;
        end else begin
            if (w_close && !w_load_out) begin
                r_stage_beats <= w_count;
            end
            if (w_load_out) begin
                r_win_beats <= (r_state == S_FILL) ? w_count : r_stage_beats;
            end
        end
    end

    assign win_beats = r_win_beats;
`endif

    assign in_ready  = w_in_ready;
    assign win_data  = r_win_data;
    assign win_valid = r_win_valid;

endmodule

`default_nettype wire

// File: doc/sample_window_capture.md
Name: sample_window_capture

Overview:
- Upstream feeder for the oversampled-bit popcount (sum) stage.
- Collects one symbol's OSF oversampled bits per input beat and assembles SAMPLES beats into one SAMPLES*OSF-bit window.
- Presents the window on a registered valid/ready output.
- Staging register plus output register, so filling of the next window overlaps with the downstream holding the current one.

Parameters:
- SAMPLES, 128: symbols (beats) per window; must be ≥2.
- OSF, 8: oversampling factor, i.e. bits per beat.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  OSF  oversampled bits of one symbol
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  block accepts a beat this cycle
- win_data  out  SAMPLES*OSF  assembled window
- win_valid  out  1  win_data valid
- win_ready  in  1  downstream consumes window this cycle
- Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Handshakes:
  - Beat accepted when in_valid && in_ready.
  - Window consumed when win_valid && win_ready.
- Packing:
  - Beat k of a window (k = 0..SAMPLES-1, arrival order) lands in win_data[k*OSF +: OSF].
  - Beat 0 occupies the LSBs, matching the 8-bit chunk order of the sum stage.
- Beat counter:
  - beat_cnt, width $clog2(SAMPLES), counts accepted beats 0..SAMPLES-1.
  - Wraps to 0 on acceptance of beat SAMPLES-1.
- State FILL (reset state):
  - in_ready = 1.
  - Each accepted beat is written into the staging register at slot beat_cnt.
  - On acceptance of the last beat: if the output slot is free (win_valid==0, or win_ready==1 this cycle), staging plus the current beat load into win_data at that same edge. win_valid=1 next cycle; stay in FILL.
  - Otherwise move to FULL.
- State FULL:
  - in_ready = 0; staging holds the complete window.
  - When the output slot frees (win_valid==0 or win_ready==1), staging loads into win_data, win_valid stays/becomes 1, state returns to FILL.
  - in_ready rises the cycle after that transfer.
- Output slot:
  - win_valid clears on consumption unless a new window loads the same edge; in that case win_valid stays 1 with new data.
  - win_data is stable while win_valid=1 and win_ready=0.
- Latency: last beat accepted at cycle N → win_valid=1 at N+1 (empty output slot).
- Throughput: one beat per cycle sustained while downstream accepts at least one window per SAMPLES cycles.
- Reset:
  - win_valid=0, win_data=0, staging=0, beat_cnt=0, state=FILL.
  - in_ready=0 while rst=1, 1 in the first cycle after deassertion.
  - Reset mid-window discards partial staging and any pending output window; no window is emitted for pre-reset beats.
- Corner cases:
  - in_valid=1 with in_ready=0: beat not taken; upstream must hold it.
  - win_ready=1 with win_valid=0: ignored.
  - Unused staging slots are never visible. Every emitted window contains exactly SAMPLES beats, except under flush (see below).

Optional Feature:
- Macro SWC_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output win_beats ($clog2(SAMPLES)+1).
  - flush=1 in FILL with beat_cnt>0 closes the partial window: unfilled slots zero-padded.
  - A beat accepted in the same cycle as flush is included.
  - The window is emitted under the normal output-slot rules (via FULL if the slot is busy).
  - win_beats = number of real beats in the window (SAMPLES for normal windows).
  - flush with beat_cnt==0 and no concurrent beat is ignored.
- Undefined: no flush port, no win_beats; only full windows are emitted.

Test Plan:
- Bench parameters SAMPLES=4, OSF=8 unless noted.
- Reset, then beats 0x11,0x22,0x33,0x44 back-to-back with win_ready=1 → win_valid=1 one cycle after beat 0x44 accepted; win_data=0x44332211; in_ready never drops.
- Window 1 emitted with win_ready=0; stream 4 more beats 0xA1..0xA4 → in_ready=0 after 0xA4; win_data holds 0x44332211. Raise win_ready one cycle → next cycle win_data=0xA4A3A2A1, in_ready=1 the following cycle.
- Continuous 3 windows with win_ready=1 and in_valid always 1 → 12 beats accepted in 12 cycles; three win_valid pulses spaced 4 cycles apart; data matches packing.
- Assert rst after 2 beats of a window, then send 0x01..0x04 → only window 0x04030201 emitted; no residue from pre-reset beats.
- SWC_FLUSH_EN: beats 0x55,0x66 then flush → win_data=0x00006655, win_beats=2. Next full window reports win_beats=4.
- Default SAMPLES=128, OSF=8: beats of 0xFF/0x00 alternating → win_data has 512 ones; feeding it to the sum stage yields 512.
